// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter for the shared fetch/load memory read bus.
// Grants one port at a time, strobes the read for READ_LATENCY cycles, then acks.
module mem_read_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  if_size,
    output logic        if_ack,
    output logic [63:0] if_data,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic [1:0]  dm_size,
    output logic        dm_ack,
    output logic [63:0] dm_data,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_size,
    output logic        mem_read,
    input  logic [63:0] mem_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_grant_dm;
    logic        r_last_grant_dm;
    logic [31:0] r_mem_address;
    logic [1:0]  r_mem_size;
    logic        r_mem_read;
    logic        r_if_ack;
    logic        r_dm_ack;
    logic [63:0] r_if_data;
    logic [63:0] r_dm_data;
    logic        r_busy;

    logic        w_any_req;
    logic        w_pick_dm;

    // On a tie the port that did not win last time gets the bus.
    assign w_any_req = if_req | dm_req;
    assign w_pick_dm = dm_req & (~if_req | ~r_last_grant_dm);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_count         <= 4'd0;
            r_grant_dm      <= 1'b0;
            r_last_grant_dm <= 1'b1;
            r_mem_address   <= 32'd0;
            r_mem_size      <= 2'd0;
            r_mem_read      <= 1'b0;
            r_if_ack        <= 1'b0;
            r_dm_ack        <= 1'b0;
            r_if_data       <= 64'd0;
            r_dm_data       <= 64'd0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    if (w_any_req) begin
                        r_grant_dm      <= w_pick_dm;
                        r_last_grant_dm <= w_pick_dm;
                        r_mem_address   <= w_pick_dm ? dm_addr : if_addr;
                        r_mem_size      <= w_pick_dm ? dm_size : if_size;
                        r_count         <= LAT_LOAD;
                        r_mem_read      <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= READ;
                    end
                end
                READ: begin
                    if (r_count == 4'd0) begin
                        r_mem_read <= 1'b0;
                        if (r_grant_dm) begin
                            r_dm_data <= mem_data;
                            r_dm_ack  <= 1'b1;
                        end else begin
                            r_if_data <= mem_data;
                            r_if_ack  <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RESP: begin
                    // No grant here, so a requester still holding req is not serviced twice.
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_mem_read <= 1'b0;
                    r_if_ack   <= 1'b0;
                    r_dm_ack   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // The down-counter is only 4 bits wide, so latencies beyond 15 cannot be honoured.
    always_ff @(posedge clock) begin
        assert (READ_LATENCY >= 1 && READ_LATENCY <= 15)
            else $error("mem_read_arbiter: READ_LATENCY=%0d outside 1..15", READ_LATENCY);
    end

    assign mem_address = r_mem_address;
    assign mem_size    = r_mem_size;
    assign mem_read    = r_mem_read;
    assign if_ack      = r_if_ack;
    assign dm_ack      = r_dm_ack;
    assign if_data     = r_if_data;
    assign dm_data     = r_dm_data;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: one instance at latency 1, one at latency 3,
// sharing clock and reset.
module tb_mem_read_arbiter;

   logic clock;
   logic reset;

   logic        ifReq1, dmReq1, ifAck1, dmAck1, memRead1, busy1;
   logic [31:0] ifAddr1, dmAddr1, memAddress1;
   logic [1:0]  ifSize1, dmSize1, memSize1;
   logic [63:0] ifData1, dmData1, memData1;

   logic        ifReq3, dmReq3, ifAck3, dmAck3, memRead3, busy3;
   logic [31:0] ifAddr3, dmAddr3, memAddress3;
   logic [1:0]  ifSize3, dmSize3, memSize3;
   logic [63:0] ifData3, dmData3, memData3;

   int errors;
   int checks;

   mem_read_arbiter #(.READ_LATENCY(1)) u_dut1 (
      .clock(clock), .reset(reset),
      .if_req(ifReq1), .if_addr(ifAddr1), .if_size(ifSize1),
      .if_ack(ifAck1), .if_data(ifData1),
      .dm_req(dmReq1), .dm_addr(dmAddr1), .dm_size(dmSize1),
      .dm_ack(dmAck1), .dm_data(dmData1),
      .mem_address(memAddress1), .mem_size(memSize1), .mem_read(memRead1),
      .mem_data(memData1), .busy(busy1)
   );

   mem_read_arbiter #(.READ_LATENCY(3)) u_dut3 (
      .clock(clock), .reset(reset),
      .if_req(ifReq3), .if_addr(ifAddr3), .if_size(ifSize3),
      .if_ack(ifAck3), .if_data(ifData3),
      .dm_req(dmReq3), .dm_addr(dmAddr3), .dm_size(dmSize3),
      .dm_ack(dmAck3), .dm_data(dmData3),
      .mem_address(memAddress3), .mem_size(memSize3), .mem_read(memRead3),
      .mem_data(memData3), .busy(busy3)
   );

   // Free-running 10-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compares one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
         else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
         end
   endtask

   // Advances to one time unit after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Holds reset over two edges and releases it just after an edge
   task automatic applyStimulus();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Linear sequence of directed scenarios
   initial begin
      errors = 0;
      checks = 0;
      ifReq1 = 0; dmReq1 = 0; ifAddr1 = 0; dmAddr1 = 0; ifSize1 = 0; dmSize1 = 0; memData1 = 0;
      ifReq3 = 0; dmReq3 = 0; ifAddr3 = 0; dmAddr3 = 0; ifSize3 = 0; dmSize3 = 0; memData3 = 0;
      applyStimulus();

      checkOutput("reset mem_read", {63'd0, memRead1}, 64'd0);
      checkOutput("reset mem_address", {32'd0, memAddress1}, 64'd0);
      checkOutput("reset mem_size", {62'd0, memSize1}, 64'd0);
      checkOutput("reset busy", {63'd0, busy1}, 64'd0);
      checkOutput("reset if_ack", {63'd0, ifAck1}, 64'd0);
      checkOutput("reset if_data", ifData1, 64'd0);
      checkOutput("reset dm_data", dmData3, 64'd0);

      $display("[TB] single fetch, latency 1");
      ifReq1 = 1; ifAddr1 = 32'h40; ifSize1 = 2'd3; memData1 = 64'h1122334455667788;
      tick();
      checkOutput("single c1 mem_read", {63'd0, memRead1}, 64'd1);
      checkOutput("single c1 mem_address", {32'd0, memAddress1}, 64'h40);
      checkOutput("single c1 mem_size", {62'd0, memSize1}, 64'd3);
      checkOutput("single c1 busy", {63'd0, busy1}, 64'd1);
      checkOutput("single c1 if_ack", {63'd0, ifAck1}, 64'd0);
      tick();
      checkOutput("single c2 mem_read", {63'd0, memRead1}, 64'd0);
      checkOutput("single c2 if_ack", {63'd0, ifAck1}, 64'd1);
      checkOutput("single c2 if_data", ifData1, 64'h1122334455667788);
      checkOutput("single c2 dm_ack", {63'd0, dmAck1}, 64'd0);
      ifReq1 = 0;
      tick();
      checkOutput("single c3 if_ack", {63'd0, ifAck1}, 64'd0);
      checkOutput("single c3 busy", {63'd0, busy1}, 64'd0);
      checkOutput("single c3 mem_read", {63'd0, memRead1}, 64'd0);

      $display("[TB] tie after reset, latency 1");
      applyStimulus();
      ifReq1 = 1; ifAddr1 = 32'h80; dmReq1 = 1; dmAddr1 = 32'h200; memData1 = 64'hA5;
      for (int c = 1; c <= 12; c++) begin
         tick();
         checkOutput($sformatf("tie c%0d if_ack", c), {63'd0, ifAck1}, {63'd0, (c == 2 || c == 8)});
         checkOutput($sformatf("tie c%0d dm_ack", c), {63'd0, dmAck1}, {63'd0, (c == 5 || c == 11)});
         checkOutput($sformatf("tie c%0d mem_read", c), {63'd0, memRead1}, {63'd0, (c % 3 == 1)});
         if (c % 3 == 1)
            checkOutput($sformatf("tie c%0d mem_address", c), {32'd0, memAddress1},
                        (c % 6 == 1) ? 64'h80 : 64'h200);
      end
      ifReq1 = 0; dmReq1 = 0;
      tick();

      $display("[TB] held request, latency 1");
      ifReq1 = 1; ifAddr1 = 32'h44; memData1 = 64'h5555AAAA5555AAAA;
      for (int c = 1; c <= 6; c++) begin
         tick();
         checkOutput($sformatf("held c%0d if_ack", c), {63'd0, ifAck1}, {63'd0, (c == 2 || c == 5)});
         checkOutput($sformatf("held c%0d mem_read", c), {63'd0, memRead1}, {63'd0, (c == 1 || c == 4)});
         checkOutput($sformatf("held c%0d dm_ack", c), {63'd0, dmAck1}, 64'd0);
         if (c == 5) ifReq1 = 0;
      end

      $display("[TB] data persistence, latency 1");
      dmReq1 = 1; dmAddr1 = 32'h300; memData1 = 64'h9988776655443322;
      tick();
      checkOutput("persist c1 mem_address", {32'd0, memAddress1}, 64'h300);
      tick();
      checkOutput("persist c2 dm_ack", {63'd0, dmAck1}, 64'd1);
      checkOutput("persist c2 dm_data", dmData1, 64'h9988776655443322);
      checkOutput("persist c2 if_data", ifData1, 64'h5555AAAA5555AAAA);
      checkOutput("persist c2 if_ack", {63'd0, ifAck1}, 64'd0);
      dmReq1 = 0;
      tick();

      $display("[TB] latency 3 data-port read");
      dmReq3 = 1; dmAddr3 = 32'h100; dmSize3 = 2'd2; memData3 = 64'hDEAD;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checkOutput($sformatf("lat3 c%0d mem_read", c), {63'd0, memRead3}, {63'd0, (c <= 3)});
         checkOutput($sformatf("lat3 c%0d dm_ack", c), {63'd0, dmAck3}, {63'd0, (c == 4)});
         if (c == 1) begin
            checkOutput("lat3 c1 mem_address", {32'd0, memAddress3}, 64'h100);
            checkOutput("lat3 c1 mem_size", {62'd0, memSize3}, 64'd2);
         end
         if (c == 4) begin
            checkOutput("lat3 c4 dm_data", dmData3, 64'hCAFEF00D12345678);
            dmReq3 = 0;
         end
         memData3 = (c == 3) ? 64'hCAFEF00D12345678 : 64'hBAD0BAD0;
      end

      $display("[TB] reset mid-READ, latency 3");
      ifReq3 = 1; ifAddr3 = 32'h10; memData3 = 64'h7777;
      tick();
      tick();
      checkOutput("abort c2 mem_read before reset", {63'd0, memRead3}, 64'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("abort mem_read async", {63'd0, memRead3}, 64'd0);
      checkOutput("abort busy", {63'd0, busy3}, 64'd0);
      checkOutput("abort if_data", ifData3, 64'd0);
      checkOutput("abort dm_data", dmData3, 64'd0);
      checkOutput("abort if_ack", {63'd0, ifAck3}, 64'd0);
      ifReq3 = 0;
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checkOutput($sformatf("abort post c%0d if_ack", c), {63'd0, ifAck3}, 64'd0);
         checkOutput($sformatf("abort post c%0d mem_read", c), {63'd0, memRead3}, 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-port read arbiter and sequencer for the shared instruction/data memory read bus. It sits between the fetch stage and the load unit on one side and the address-decoded memory devices (ROM, RAM, each with its own chip-select and tristate data output) on the other. It grants one requester at a time with round-robin fairness and drives `mem_address`, `mem_size` and `mem_read` for a fixed read latency. It captures the 64-bit return data and hands it back with a one-cycle acknowledge.

## Interface
- `READ_LATENCY`, 1: clock edges from first `mem_read` cycle to valid `mem_data`; legal range 1..15.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch read request; held high with stable `if_addr`/`if_size` until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_size`  in  2  fetch access size code, passed through to memory.
- `if_ack`  out  1  one-cycle pulse: `if_data` valid.
- `if_data`  out  64  fetch return data, held until next `if_ack`.
- `dm_req`, `dm_addr`, `dm_size`, `dm_ack`, `dm_data`: same as above for the load unit.
- `mem_address`  out  32  registered address to all memory devices.
- `mem_size`  out  2  registered size code.
- `mem_read`  out  1  read strobe; devices drive `mem_data` only while selected and strobed.
- `mem_data`  in  64  shared memory read data.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, RESP.
- **IDLE**
  - If no request: stay in IDLE, `mem_read`=0.
  - Exactly one `*_req` high: grant it.
  - Both high: grant the port not granted last (`last_grant`).
  - On grant: latch `mem_address`/`mem_size` from the granted port, set `last_grant`, load the latency counter with `READ_LATENCY-1`, go to READ.
- **READ**
  - `mem_read`=1; address and size held constant.
  - Counter decrements each cycle. At count 0, capture `mem_data` into the granted port's data register and go to RESP.
  - New requests are ignored in READ.
- **RESP**
  - Assert the granted port's `*_ack` for exactly one cycle; `mem_read`=0. Go to IDLE.
  - No grant in RESP, so the just-acked requester's still-high `req` is never double-serviced.
  - The requester must drop `req` or present a new address in the cycle after ack.
- Ungranted port's data register and ack are never touched.
- An unmapped address leaves `mem_data` undriven. The captured value is whatever the bus holds; no error signalling.
- Counter is 4 bits. `READ_LATENCY` outside 1..15 is a configuration error; flag it with a simulation-time check.

## Timing
- Request first high in IDLE in cycle 0. `mem_read`=1 in cycles 1..READ_LATENCY. `*_ack`=1 in cycle READ_LATENCY+1. IDLE again in cycle READ_LATENCY+2.
- Minimum spacing between grants is READ_LATENCY+2 cycles.
- With both ports requesting continuously, grants strictly alternate.
- Reset values:
  - state IDLE
  - `mem_read`=0, `mem_address`=0, `mem_size`=0
  - `if_ack`=`dm_ack`=0, `if_data`=`dm_data`=0
  - `busy`=0
  - `last_grant`=data port, so fetch wins the first tie.
- Reset mid-READ/RESP: immediate return to IDLE, `mem_read` drops asynchronously, no ack is ever issued for the aborted transaction, data registers are cleared.
- A request arriving in the same cycle as another port's ack (RESP) is granted in the following IDLE cycle.
- All outputs are registered; there are no combinational paths from `*_req` to `mem_*`.

## Test plan
- **Single fetch, READ_LATENCY=1.**
  - Stimulus: `if_req`, `if_addr`=0x40, memory returns 0x1122334455667788.
  - Required: `mem_read` high cycle 1 only, `mem_address`=0x40; `if_ack` high cycle 2 with `if_data`=0x1122334455667788; `dm_ack` never high.
- **Tie after reset, READ_LATENCY=1.**
  - Stimulus: `if_req`, `dm_req` both held high.
  - Required: grant order fetch, data, fetch, data; acks in cycles 2, 5, 8, 11.
- **READ_LATENCY=3.**
  - Stimulus: `dm_req`, `dm_addr`=0x100, memory data valid only in cycle 3.
  - Required: `mem_read` high cycles 1-3; `dm_ack` in cycle 4 with the cycle-3 value.
- **Held request.**
  - Stimulus: `if_req` held high through ack.
  - Required: exactly one ack per grant, next grant starts in the IDLE cycle after RESP.
- **Reset mid-READ.**
  - Stimulus: reset asserted during READ with READ_LATENCY=3.
  - Required: `mem_read` falls without a clock edge; no ack; `if_data`/`dm_data`=0; `busy`=0.
- **Data persistence.**
  - Stimulus: `if_data` acked, then a data-port transaction.
  - Required: `if_data` unchanged while `dm_data` updates.
